// File: rtl/hls_profiler_pkg.sv
// Shared types, read-select codes and the saturating-increment helper for the
// HLS handshake profiler.
package hls_profiler_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2
   } chan_state_e;

   localparam int NUM_SEL   = 8;
   localparam int SAT_MAX_W = 64;

   localparam logic [2:0] SEL_START = 3'd0;
   localparam logic [2:0] SEL_DONE  = 3'd1;
   localparam logic [2:0] SEL_BUSY  = 3'd2;
   localparam logic [2:0] SEL_STALL = 3'd3;
   localparam logic [2:0] SEL_LAST  = 3'd4;
   localparam logic [2:0] SEL_MAX   = 3'd5;
   localparam logic [2:0] SEL_MIN   = 3'd6;
   localparam logic [2:0] SEL_ITER  = 3'd7;

   // Counters up to SAT_MAX_W bits wide; sat is high when the increment was clipped.
   function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                   input int width,
                                                   output logic sat);
      logic [SAT_MAX_W-1:0] lim;
      if (width >= SAT_MAX_W) lim = '1;
      else                    lim = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
      sat = (val >= lim);
      return sat ? lim : val + SAT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/hls_profiler_chan.sv
// One monitored channel: handshake FSM plus saturating statistics counters.
// PROF_LOOP_EN adds the loop-iteration counter on select 7.
//
//   state | meaning
//   IDLE  | no transaction in flight
//   RUN   | started, waiting for ap_done
//   WAIT  | done seen, downstream holding ap_continue low
module hls_profiler_chan
   import hls_profiler_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            freeze_i,
   input  logic                            ap_start_i,
   input  logic                            ap_ready_i,
   input  logic                            ap_done_i,
   input  logic                            ap_continue_i,
   input  logic                            iter_i,
   output logic [NUM_SEL-1:0][CNT_W-1:0]   stats_o,
   output logic                            ovf_o
);

   chan_state_e      state_q, state_d;
   logic [CNT_W-1:0] start_q, start_d, done_q, done_d, busy_q, busy_d;
   logic [CNT_W-1:0] stall_q, stall_d, lat_q, lat_d, last_q, last_d;
   logic [CNT_W-1:0] max_q, max_d, min_q, min_d, ready_q, ready_d;
   logic             ovf_q, ovf_d;
   logic             s, sat_any, rec, unused_rdy_sat;
   logic [CNT_W-1:0] rec_lat, lat_inc;
`ifdef PROF_LOOP_EN
   logic [CNT_W-1:0] iter_q, iter_d;
`else
   logic             unused_iter;
   assign unused_iter = iter_i;
`endif

   function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v, output logic sat);
      return CNT_W'(sat_inc(SAT_MAX_W'(v), CNT_W, sat));
   endfunction

   always_comb begin
      state_d        = state_q;
      start_d        = start_q;
      done_d         = done_q;
      busy_d         = busy_q;
      stall_d        = stall_q;
      lat_d          = lat_q;
      last_d         = last_q;
      max_d          = max_q;
      min_d          = min_q;
      ready_d        = ready_q;
      ovf_d          = ovf_q;
`ifdef PROF_LOOP_EN
      iter_d         = iter_q;
`endif
      s              = 1'b0;
      sat_any        = 1'b0;
      rec            = 1'b0;
      rec_lat        = '0;
      lat_inc        = lat_q;
      unused_rdy_sat = 1'b0;
      if (!freeze_i) begin
         unique case (state_q)
            IDLE: begin
               if (ap_start_i) begin
                  start_d = inc_sat(start_q, s);
                  sat_any = sat_any | s;
                  lat_d   = '0;
                  if (ap_done_i) begin
                     rec     = 1'b1;
                     state_d = ap_continue_i ? IDLE : WAIT;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               busy_d  = inc_sat(busy_q, s);
               sat_any = sat_any | s;
               lat_inc = inc_sat(lat_q, s);
               sat_any = sat_any | s;
               lat_d   = lat_inc;
`ifdef PROF_LOOP_EN
               if (iter_i) begin
                  iter_d  = inc_sat(iter_q, s);
                  sat_any = sat_any | s;
               end
`endif
               if (ap_done_i) begin
                  rec     = 1'b1;
                  rec_lat = lat_inc;
                  if (!ap_continue_i) begin
                     state_d = WAIT;
                  end else if (ap_start_i) begin
                     start_d = inc_sat(start_q, s);
                     sat_any = sat_any | s;
                     lat_d   = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            WAIT: begin
               stall_d = inc_sat(stall_q, s);
               sat_any = sat_any | s;
               if (ap_continue_i) begin
                  if (ap_start_i) begin
                     start_d = inc_sat(start_q, s);
                     sat_any = sat_any | s;
                     lat_d   = '0;
                     state_d = RUN;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
         if (rec) begin
            done_d  = inc_sat(done_q, s);
            sat_any = sat_any | s;
            last_d  = rec_lat;
            if (rec_lat > max_q) max_d = rec_lat;
            if (rec_lat < min_q) min_d = rec_lat;
         end
         // ready_cnt has no read path, so it is kept out of the overflow flag and trims away
         if (ap_ready_i && state_q != WAIT) ready_d = inc_sat(ready_q, unused_rdy_sat);
         if (sat_any) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         start_q <= '0;
         done_q  <= '0;
         busy_q  <= '0;
         stall_q <= '0;
         lat_q   <= '0;
         last_q  <= '0;
         max_q   <= '0;
         min_q   <= '1;
         ready_q <= '0;
         ovf_q   <= 1'b0;
`ifdef PROF_LOOP_EN
         iter_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         stall_q <= stall_d;
         lat_q   <= lat_d;
         last_q  <= last_d;
         max_q   <= max_d;
         min_q   <= min_d;
         ready_q <= ready_d;
         ovf_q   <= ovf_d;
`ifdef PROF_LOOP_EN
         iter_q  <= iter_d;
`endif
      end
   end

   assign stats_o[SEL_START] = start_q;
   assign stats_o[SEL_DONE]  = done_q;
   assign stats_o[SEL_BUSY]  = busy_q;
   assign stats_o[SEL_STALL] = stall_q;
   assign stats_o[SEL_LAST]  = last_q;
   assign stats_o[SEL_MAX]   = max_q;
   assign stats_o[SEL_MIN]   = min_q;
`ifdef PROF_LOOP_EN
   assign stats_o[SEL_ITER]  = iter_q;
`else
   assign stats_o[SEL_ITER]  = '0;
`endif
   assign ovf_o = ovf_q;

endmodule

// File: rtl/hls_handshake_profiler.sv
// Top of the HLS handshake profiler: NUM_CH channel monitors, sticky freeze on
// finish and a registered read mux. Optional loop counting via PROF_LOOP_EN.
module hls_handshake_profiler
   import hls_profiler_pkg::*;
#(
   parameter int NUM_CH = 11,
   parameter int CNT_W  = 32,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              finish,
   input  logic [NUM_CH-1:0] ap_start,
   input  logic [NUM_CH-1:0] ap_ready,
   input  logic [NUM_CH-1:0] ap_done,
   input  logic [NUM_CH-1:0] ap_continue,
   input  logic [NUM_CH-1:0] iter_start,
   input  logic              rd_req,
   input  logic [CH_W-1:0]   rd_ch,
   input  logic [2:0]        rd_sel,
   output logic              rd_ack,
   output logic [CNT_W-1:0]  rd_data,
   output logic [NUM_CH-1:0] overflow,
   output logic              frozen
);

   logic                          frozen_q;
   logic                          rd_ack_q;
   logic [CNT_W-1:0]              rd_data_q, rd_data_d;
   logic [NUM_SEL-1:0][CNT_W-1:0] stats [NUM_CH];

   // Channels see the registered flag, so a done coinciding with finish still lands.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      hls_profiler_chan #(
         .CNT_W(CNT_W)
      ) u_chan (
         .clock         (clock),
         .reset         (reset),
         .freeze_i      (frozen_q),
         .ap_start_i    (ap_start[c]),
         .ap_ready_i    (ap_ready[c]),
         .ap_done_i     (ap_done[c]),
         .ap_continue_i (ap_continue[c]),
         .iter_i        (iter_start[c]),
         .stats_o       (stats[c]),
         .ovf_o         (overflow[c])
      );
   end

   always_comb begin
      rd_data_d = '0;
      if (rd_req) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c)) rd_data_d = stats[c][rd_sel];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         frozen_q  <= 1'b0;
         rd_ack_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         frozen_q  <= frozen_q | finish;
         rd_ack_q  <= rd_req;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_ack  = rd_ack_q;
   assign rd_data = rd_data_q;
   assign frozen  = frozen_q;

endmodule

// File: doc/hls_handshake_profiler.md
Name: hls_handshake_profiler

Overview:
- Synthesizable, parametrised profiler for HLS block-level handshakes (ap_start/ap_ready/ap_done/ap_continue) across NUM_CH monitored modules.
- Sits beside the top-level kernel in co-sim and on-board builds.
- Per channel it counts transactions, busy cycles, back-pressure stalls and latency statistics.
- A registered read port exposes the results; unlike file-dumping monitors, it also records min/max latency and continue-stall time.

Parameters:
- NUM_CH, 11, number of monitored modules.
- CNT_W, 32, width of every counter and of rd_data.
- CH_W, $clog2(NUM_CH) (minimum 1), width of rd_ch.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- finish  in  1  end of run; freezes all statistics.
- ap_start  in  NUM_CH  per-channel start.
- ap_ready  in  NUM_CH  per-channel ready (informational, counted only).
- ap_done  in  NUM_CH  per-channel done.
- ap_continue  in  NUM_CH  per-channel continue; tie to 1 for non-dataflow modules.
- iter_start  in  NUM_CH  loop iteration-start strobe; used only with PROF_LOOP_EN.
- rd_req  in  1  read request, one-cycle pulse.
- rd_ch  in  CH_W  channel to read.
- rd_sel  in  3  counter select.
- rd_ack  out  1  read data valid.
- rd_data  out  CNT_W  read data.
- overflow  out  NUM_CH  sticky per-channel saturation flag.
- frozen  out  1  high once finish has been seen.

Behaviour:
- Reset (synchronous, active high): all counters = 0, min_lat = all-ones, every FSM in IDLE, rd_ack = 0, rd_data = 0, overflow = 0, frozen = 0.
- Reset asserted mid-transaction aborts it. No latency is recorded.

Per-channel FSM (states IDLE, RUN, WAIT):
- IDLE:
  - ap_start=1 starts a transaction: start_cnt+1, lat=0.
  - If ap_done & ap_continue in the same cycle: record latency 0 and stay IDLE.
  - If ap_done & !ap_continue in the same cycle: go to WAIT.
  - Otherwise go to RUN.
- RUN:
  - busy_cycles+1 and lat+1 every cycle.
  - ap_done & ap_continue: record, then go to RUN if ap_start=1 (new transaction, lat=0, start_cnt+1), else IDLE.
  - ap_done & !ap_continue: record, then go to WAIT.
- WAIT:
  - stall_cycles+1 every cycle.
  - ap_continue=1: go to RUN if ap_start=1 (start_cnt+1), else IDLE.
- "Record" means:
  - done_cnt+1
  - last_lat = lat
  - max_lat = max(max_lat, lat)
  - min_lat = min(min_lat, lat)
- ready_cnt+1 on every cycle where ap_ready=1 and the channel is not in WAIT.

Arithmetic:
- All counters saturate at 2^CNT_W-1; they never wrap.
- The first saturation on a channel sets that channel's overflow bit. It clears only on reset.

finish:
- Sampled each cycle. Once high, frozen=1 (sticky until reset).
- All counters and FSMs hold their values; the read port keeps working.
- finish in the same cycle as done: that final done is recorded, and counters freeze from the next cycle.

Read port:
- rd_req sampled at edge N; rd_ack=1 and rd_data valid at edge N+1 for one cycle. Back-to-back requests are allowed, one per cycle.
- rd_sel codes:
  - 0 start_cnt
  - 1 done_cnt
  - 2 busy_cycles
  - 3 stall_cycles
  - 4 last_lat
  - 5 max_lat
  - 6 min_lat (all-ones if no transaction has completed)
  - 7 iter_cnt (0 without PROF_LOOP_EN)
- rd_ch >= NUM_CH: rd_ack=1, rd_data=0.
- A read in the same cycle as a counter update returns the pre-update value.
- ready_cnt is not readable in the base build; it is reserved for a future select-width extension and is stripped by synthesis.

Optional Feature:
- Macro: PROF_LOOP_EN.
- With the macro defined:
  - per-channel iter_cnt increments on iter_start=1 while the channel is in RUN (saturating, feeds overflow);
  - rd_sel=7 returns iter_cnt.
- Without the macro: iter_start is ignored, no iter_cnt register exists, and rd_sel=7 returns 0.

Decomposition:
- Package hls_profiler_pkg:
  - state enum {IDLE, RUN, WAIT};
  - rd_sel code constants;
  - CNT_W-generic saturating-increment function with overflow output.
- Sub-module hls_profiler_chan: one channel's FSM and counters, instantiated NUM_CH times by generate.
- Top level holds the finish/frozen logic and the registered read mux.

Test Plan:
- Reset, then reads of ch0 with rd_sel 0..7 -> rd_ack one cycle after each rd_req; data 0,0,0,0,0,0,all-ones,0.
- ch2: start at cycle 10, done & continue at cycle 15 -> start_cnt=1, done_cnt=1, last_lat=5, busy_cycles=5, FSM back to IDLE.
- ch1: done with continue=0 held for 3 cycles -> stall_cycles=3; busy_cycles does not increase during WAIT; ap_start high at release -> start_cnt=2.
- Three transactions on ch3 with latencies 4, 9, 2 -> min_lat=2, max_lat=9, last_lat=2.
- CNT_W=4, run 20 busy cycles on ch0 -> busy_cycles=15, overflow[0]=1, other overflow bits 0.
- Assert finish mid-RUN on ch4, then continue toggling inputs -> frozen=1; all reads are unchanged over 10 further cycles; rd_ch=NUM_CH returns 0 with ack.
